// File: rtl/bus_interconnect.sv
// bus_interconnect: single-master, N-slave memory-mapped fabric with base/mask window decode.
// Latency: unmapped/RO-write 1 cycle; mapped 1 cycle after selected s_ready; timeout TIMEOUT_CYCLES+1.
// Backpressure: one transaction in flight; master holds request until m_ready, slaves stall via s_ready.
// Optional: define BUS_FAULT_LOG_EN to add fault_addr/fault_code/fault_count/fault_irq.
module bus_interconnect #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE =
    {32'hF1000000, 32'hF0000000, 32'h00010000, 32'h00000000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK =
    {32'hFFFFFFF8, 32'hFFFFFFF0, 32'hFFFF0000, 32'hFFFF0000},
  parameter logic [NUM_SLAVES-1:0] SLAVE_RO = 4'b0001,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA = 32'h00000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     m_valid,
  input  logic                     m_instr,
  input  logic                     m_we,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  output logic [31:0]              m_rdata,
  output logic                     m_ready,
  output logic                     m_error,
  output logic [NUM_SLAVES-1:0]    s_valid,
  output logic                     s_we,
  output logic                     s_instr,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]    s_ready
`ifdef BUS_FAULT_LOG_EN
  ,
  output logic [31:0]              fault_addr,
  output logic [1:0]               fault_code,
  output logic [15:0]              fault_count,
  output logic [0:0]               fault_irq
`endif
);

  localparam int IDXW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state, nextState;
  logic                    hit;
  logic [IDXW-1:0]         hitIdx;
  logic [IDXW-1:0]         selIdx;
  logic [NUM_SLAVES-1:0]   hitOneHot;
  logic [15:0]             count;
  logic                    roWrite, accept, reject, slaveDone, timedOut;

  // Address decode: scan from the top index down so the lowest-index hit is left standing.
  always_comb begin
    hit       = 1'b0;
    hitIdx    = '0;
    hitOneHot = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit    = 1'b1;
        hitIdx = IDXW'(i);
      end
    end
    hitOneHot[hitIdx] = hit;
  end

  assign roWrite   = m_we & SLAVE_RO[hitIdx];
  assign accept    = (state == IDLE) & m_valid & hit & ~roWrite;
  assign reject    = (state == IDLE) & m_valid & ~(hit & ~roWrite);
  // Ready from the selected slave beats a same-cycle timeout.
  assign slaveDone = (state == ACCESS) & s_ready[selIdx];
  assign timedOut  = (state == ACCESS) & ~s_ready[selIdx] & (count == TIMEOUT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = ACCESS;
               else if (reject) nextState = RESP;
      ACCESS:  if (slaveDone || timedOut) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request/response datapath: latch the request on accept, build the registered response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_rdata <= '0;
      m_ready <= 1'b0;
      m_error <= 1'b0;
      s_valid <= '0;
      s_we    <= 1'b0;
      s_instr <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      selIdx  <= '0;
      count   <= '0;
    end else begin
      m_ready <= reject | slaveDone | timedOut;
      m_error <= reject | timedOut;
      if (accept) begin
        selIdx  <= hitIdx;
        s_valid <= hitOneHot;
        s_we    <= m_we;
        s_instr <= m_instr;
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
      end
      if (slaveDone) begin
        m_rdata <= s_rdata[{selIdx, 5'b0} +: 32];
      end else if (reject || timedOut) begin
        m_rdata <= ERR_RDATA;
      end
      if (slaveDone || timedOut) s_valid <= '0;
      if (state == ACCESS)    count <= count + 16'd1;
      else if (state == RESP) count <= '0;
    end
  end

`ifdef BUS_FAULT_LOG_EN
  // Fault log: capture address and cause of every error response, saturating count, one-cycle irq.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fault_addr  <= '0;
      fault_code  <= '0;
      fault_count <= '0;
      fault_irq   <= '0;
    end else begin
      fault_irq <= reject | timedOut;
      if (reject || timedOut) begin
        fault_addr <= reject ? m_addr : s_addr;
        fault_code <= timedOut ? 2'd3 : (hit ? 2'd2 : 2'd1);
        if (fault_count != 16'hFFFF) fault_count <= fault_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/bus_interconnect.md
Name: bus_interconnect

Overview:
Parametrised single-master, N-slave memory-mapped bus fabric that replaces the hard-coded chip-select decode and read mux in the SoC top level. It decodes m_addr against per-slave base/mask windows, forwards one transaction at a time to the selected slave and returns a registered response. It adds features the flat decode lacks: wait-state support via per-slave ready, a timeout, write protection and error signalling for unmapped accesses.

Parameters:
NUM_SLAVES, 4, number of slave ports (1..16)
SLAVE_BASE, {32'hF1000000,32'hF0000000,32'h00010000,32'h00000000}, packed NUM_SLAVES*32 base addresses; slave i occupies bits [32*i+31:32*i]
SLAVE_MASK, {32'hFFFFFFF8,32'hFFFFFFF0,32'hFFFF0000,32'hFFFF0000}, packed decode masks; hit(i) = (m_addr & MASK_i) == BASE_i
SLAVE_RO, 4'b0001, per-slave write-protect bit; bit i=1 makes slave i read-only
TIMEOUT_CYCLES, 255, ACCESS cycles before abort (1..65535)
ERR_RDATA, 32'h00000000, m_rdata value returned on any error

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
m_valid  in  1  master request; address, data, we and instr held stable until m_ready
m_instr  in  1  instruction fetch flag; passed through as s_instr
m_we  in  1  write enable
m_addr  in  32  byte address
m_wdata  in  32  write data
m_rdata  out  32  registered read data; valid while m_ready=1
m_ready  out  1  one-cycle response pulse
m_error  out  1  valid with m_ready: unmapped, RO-write or timeout
s_valid  out  NUM_SLAVES  one-hot request to selected slave
s_we  out  1  registered write enable
s_instr  out  1  registered instr flag
s_addr  out  32  registered address
s_wdata  out  32  registered write data
s_rdata  in  NUM_SLAVES*32  packed slave read data
s_ready  in  NUM_SLAVES  per-slave completion, sampled only for the selected slave

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE; m_ready=0, m_error=0, m_rdata=0, s_valid=0, s_we=0, s_instr=0, s_addr=0, s_wdata=0, timeout counter=0. Reset overrides any state, so an in-flight slave access is dropped on the next edge with no response.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: while m_valid=0, stay. When m_valid=1, decode combinationally. The lowest-index hit wins.
  - Mapped and not (m_we & SLAVE_RO[idx]): register idx, addr, wdata, we and instr; set s_valid[idx]=1; go to ACCESS.
  - No hit, or write to an RO slave: go to RESP with error=1 and rdata=ERR_RDATA. No s_valid is raised.
- ACCESS: s_valid[idx] stays high, and the counter increments each cycle.
  - If s_ready[idx]=1: capture s_rdata[idx] (writes capture it too, and it is ignored), drop s_valid, go to RESP with error=0.
  - Else if counter==TIMEOUT_CYCLES-1: drop s_valid, go to RESP with error=1 and rdata=ERR_RDATA.
  - s_ready and timeout in the same cycle: ready wins.
- RESP: m_ready=1 for exactly one cycle, with m_rdata and m_error; counter cleared; return to IDLE. Outside RESP, m_ready=0 and m_error=0; m_rdata holds its last value.
- Master contract: the cycle after m_ready, m_valid must be 0 or present a new request. A new request is accepted in IDLE, giving back-to-back transfers at one every 3+ cycles.
- Latency:
  - mapped: m_valid at cycle 0, s_valid from cycle 1; m_ready comes 1 cycle after s_ready is sampled high (minimum cycle 2).
  - unmapped or RO: m_ready at cycle 1.
  - timeout: m_ready at cycle TIMEOUT_CYCLES+1.
- s_ready from non-selected slaves is ignored. s_valid is never asserted on more than one bit.
- m_valid dropping mid-ACCESS is a protocol violation; the transaction still completes and responds.

Optional Feature:
BUS_FAULT_LOG_EN:
- Defined: adds outputs fault_addr[31:0], fault_code[1:0] (1=unmapped, 2=RO write, 3=timeout), fault_count[15:0] and fault_irq[0:0].
- On each error response, in the RESP cycle: latch fault_addr and fault_code; increment fault_count, saturating at 16'hFFFF; pulse fault_irq for one cycle.
- All four outputs reset to 0. The latched fault_addr and fault_code hold until the next fault.
- Undefined: the ports and logic are absent, and the error response is unchanged.

Test Plan:
- Read 0x00000010, slave0 s_ready 1 cycle after s_valid, s_rdata0=0x12345678 -> s_valid=4'b0001 at cycle 1; m_ready at cycle 3 with m_rdata=0x12345678, m_error=0.
- Write 0x0001_0004 data 0xCAFEF00D, slave1 ready after 3 cycles -> s_valid=4'b0010, s_we=1, s_wdata=0xCAFEF00D, s_addr=0x00010004; m_ready with m_error=0.
- Write 0x00000000 (slave0 RO), then read 0x20000000 (unmapped) -> each gives m_ready at cycle 1 with m_error=1 and m_rdata=0; s_valid never asserted. With the macro defined: fault_code 2 then 1, fault_count=2.
- Read 0xF1000004 with TIMEOUT_CYCLES=8 and s_ready3 held 0 -> s_valid[3] high for 8 cycles; m_ready at cycle 9 with m_error=1; slave 3 sees s_ready arrive late and ignores it. With the macro defined: fault_code=3, fault_addr=0xF1000004.
- Back-to-back reads of 0xF0000000 then 0xF0000008, with windows overlapping via a test parameterisation -> lowest index selected; second request accepted the cycle after the first m_ready.
- reset=0 asserted during ACCESS -> next edge s_valid=0, no m_ready pulse, state IDLE. After release, a read of slave2 completes normally.
